// File: rtl/fetch_unit.sv
// Instruction-fetch control: owns the PC, tracks the one-cycle registered
// memory latency, and buffers the output word across downstream stalls.
//
// state | meaning
// FILL  | no live word in flight (after reset or redirect); issue pc
// RUN   | word for fetch_pc arrives on instr_in (or sits in the hold buffer)
module fetch_unit #(
  parameter int          MEM_DEPTH = 16,
  parameter logic [15:0] NOP_WORD  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] read_address,
  input  logic [15:0] instr_in,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr
);

  // MEM_DEPTH is a power of two, so masking gives modulo wrap and truncation.
  localparam logic [15:0] ADDR_MASK = 16'(MEM_DEPTH - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        held_q, held_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [15:0] pc_inc;

  assign pc_inc = (pc_q + 16'd1) & ADDR_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      pc_q         <= 16'h0000;
      fetch_pc_q   <= 16'h0000;
      held_q       <= 1'b0;
      hold_instr_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      held_q       <= held_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    held_d       = held_q;
    hold_instr_d = hold_instr_q;
    if (redirect) begin
      // In-flight word and any stall buffer are squashed.
      pc_d    = redirect_pc & ADDR_MASK;
      state_d = FILL;
      held_d  = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          fetch_pc_d = pc_q;
          pc_d       = pc_inc;
          state_d    = RUN;
        end
        RUN: begin
          if (!stall) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_inc;
            held_d     = 1'b0;
          end else if (!held_q) begin
            // Memory has no read enable: capture the word before it is overwritten.
            hold_instr_d = instr_in;
            held_d       = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign read_address = pc_q;
  assign if_valid     = (state_q == RUN);
  assign if_pc        = fetch_pc_q;
  assign if_instr     = (state_q != RUN) ? NOP_WORD :
                        (held_q ? hold_instr_q : instr_in);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction-memory model
// and a scoreboard of expected (pc, instruction) pairs.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] read_address;
  logic [15:0] instr_in = 16'h0000;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_instr;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] tb_mem [16];
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_unit #(.MEM_DEPTH(16), .NOP_WORD(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .read_address (read_address),
    .instr_in     (instr_in),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  always #5 clk = ~clk;

  // Registered-output instruction memory.
  always @(posedge clk) instr_in <= tb_mem[read_address[3:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    sb.push_back('{pc: pc, instr: tb_mem[pc[3:0]]});
  endtask

  // Compare presented output with scoreboard head; pop only when consumed.
  task automatic present(input string tag, input bit pop);
    exp_t e;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb_empty: observed size 0 expected size >0", tag);
    end
    if (sb.size() > 0) begin
      e = sb[0];
      chk({tag, "_valid"}, {15'd0, if_valid}, 16'd1);
      chk({tag, "_pc"}, if_pc, e.pc);
      chk({tag, "_instr"}, if_instr, e.instr);
      if (pop) void'(sb.pop_front());
    end
  endtask

  task automatic bubble(input string tag);
    chk({tag, "_valid"}, {15'd0, if_valid}, 16'd0);
    chk({tag, "_instr"}, if_instr, NOP);
  endtask

  initial begin
    tb_mem[0] = 16'h1010;
    tb_mem[1] = 16'h1231;
    tb_mem[2] = 16'h145e;
    tb_mem[3] = 16'h167f;
    for (int i = 4; i < 16; i++) tb_mem[i] = 16'hA000 | 16'(i);

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    tick();
    tick();

    // Reset state (FILL cycle)
    bubble("reset");
    chk("reset_ra", read_address, 16'h0000);
    chk("reset_pc", if_pc, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(16'(i));
    tick();

    present("run0", 1'b1);
    chk("run0_ra", read_address, 16'h0001);
    tick();

    // Stall for 3 cycles while (1,1231) presented
    present("stall_first", 1'b0);
    chk("stall_ra0", read_address, 16'h0002);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      present("stall_hold", 1'b0);
      chk("stall_ra", read_address, 16'h0002);
    end
    tick();
    present("stall_release", 1'b1);
    chk("stall_ra_rel", read_address, 16'h0002);
    stall = 1'b0;
    tick();

    // Redirect to 0 while (2,145e) presented
    present("after_stall", 1'b1);
    redirect = 1'b1; redirect_pc = 16'h0000;
    sb.delete();
    push(16'h0000); push(16'h0001);
    tick();
    redirect = 1'b0;
    bubble("redir_bubble");
    chk("redir_ra", read_address, 16'h0000);
    tick();
    present("redir_t0", 1'b1);
    tick();

    // Stall one cycle (buffer filled), then redirect+stall to 3
    present("rs_first", 1'b0);
    stall = 1'b1;
    tick();
    present("rs_held", 1'b0);
    redirect = 1'b1; redirect_pc = 16'h0003;
    sb.delete();
    push(16'h0003); push(16'h0004);
    tick();
    redirect = 1'b0; stall = 1'b0;
    bubble("rs_bubble");
    chk("rs_ra", read_address, 16'h0003);
    tick();
    present("rs_target", 1'b1);
    tick();
    present("rs_next", 1'b1);

    // Wrap/truncate: 0x001F -> 15 -> 0
    redirect = 1'b1; redirect_pc = 16'h001F;
    sb.delete();
    push(16'h000F); push(16'h0000); push(16'h0001);
    tick();
    redirect = 1'b0;
    bubble("wrap_bubble");
    chk("wrap_ra15", read_address, 16'h000F);
    tick();
    present("wrap_15", 1'b1);
    chk("wrap_ra0", read_address, 16'h0000);
    tick();
    present("wrap_0", 1'b1);
    chk("wrap_ra1", read_address, 16'h0001);
    tick();

    // Mid-operation reset with held=1
    present("mr_first", 1'b0);
    stall = 1'b1;
    tick();
    present("mr_held", 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    bubble("mr_reset");
    chk("mr_ra", read_address, 16'h0000);
    sb.delete();
    push(16'h0000); push(16'h0001);
    tick();
    present("mr_run0", 1'b1);
    tick();
    present("mr_run1", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
